// File: rtl/am_nco_modulator.sv
// AM modulator with internal NCO carrier: phase accumulator, quarter-wave sine LUT,
// AM / DSB-SC / carrier / mute envelope, 4-stage pipeline to an offset-binary DAC word.
module am_nco_modulator #(
   parameter int IN_W    = 12,
   parameter int CAR_W   = 12,
   parameter int DAC_W   = 14,
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 8,
   parameter bit INVERT  = 1'b0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [IN_W-1:0]    mod_in,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [PHASE_W-1:0] cfg_ftw,
   input  logic [7:0]         cfg_depth,
   input  logic [1:0]         cfg_mode,
   output logic [DAC_W-1:0]   dac_out,
   output logic               out_valid,
   output logic               phase_wrap
);

   localparam int E_W  = IN_W + 2;
   localparam int P_W  = E_W + CAR_W;
   localparam int MD_W = IN_W + 9;
   localparam int SH   = IN_W + CAR_W - DAC_W;
   localparam int N    = 2 ** LUT_AW;
   localparam int Q_W  = LUT_AW + 2;

   localparam logic [DAC_W-1:0] INV_MASK = INVERT ? '1 : '0;
   localparam logic [DAC_W-1:0] MID =
      {1'b1, {(DAC_W-1){1'b0}}} ^ INV_MASK;
   localparam logic signed [E_W-1:0] HALF = E_W'(2 ** (IN_W-1));
   localparam logic signed [P_W-1:0] SMAX = P_W'(2 ** (DAC_W-1) - 1);
   localparam logic signed [P_W-1:0] SMIN = -SMAX - P_W'(1);

   typedef enum logic [1:0] {
      M_AM   = 2'd0,
      M_DSB  = 2'd1,
      M_CAR  = 2'd2,
      M_MUTE = 2'd3
   } mode_t;

   // sin over the first quadrant by Taylor series, sampled at bin centres
   function automatic logic signed [CAR_W-1:0] lut_entry(input int a);
      real x, t, s;
      x = 2.0 * 3.14159265358979323846 * ($itor(a) + 0.5) / $itor(4 * N);
      t = x;
      s = x;
      for (int k = 1; k < 12; k++) begin
         t = -t * x * x / $itor((2 * k) * (2 * k + 1));
         s = s + t;
      end
      return CAR_W'($rtoi(s * $itor(2 ** (CAR_W-1) - 1) + 0.5));
   endfunction

   logic signed [CAR_W-1:0] lut [N];

   for (genvar i = 0; i < N; i++) begin : g_lut
      localparam logic signed [CAR_W-1:0] V = lut_entry(i);
      assign lut[i] = V;
   end

   logic [PHASE_W-1:0] phase, ftw_a, ftw_s;
   logic [7:0]         dep_a, dep_s;
   mode_t              mode_a, mode_s;
   logic               pend;
   logic [PHASE_W:0]   sum;
   logic               apply;

   assign sum       = {1'b0, phase} + {1'b0, ftw_a};
   assign apply     = pend && (sum[PHASE_W] || ftw_a == '0);
   assign cfg_ready = ~pend;

   always_ff @(posedge CLK) begin
      if (RST) begin
         phase      <= '0;
         phase_wrap <= 1'b0;
         ftw_a      <= '0;
         dep_a      <= '0;
         mode_a     <= M_AM;
         ftw_s      <= '0;
         dep_s      <= '0;
         mode_s     <= M_AM;
         pend       <= 1'b0;
      end else begin
         phase      <= sum[PHASE_W-1:0];
         phase_wrap <= sum[PHASE_W];
         if (cfg_valid && !pend) begin
            ftw_s  <= cfg_ftw;
            dep_s  <= cfg_depth;
            mode_s <= mode_t'(cfg_mode);
            pend   <= 1'b1;
         end else if (apply) begin
            ftw_a  <= ftw_s;
            dep_a  <= dep_s;
            mode_a <= mode_s;
            pend   <= 1'b0;
         end
      end
   end

   logic [IN_W-1:0]         mod1;
   logic [Q_W-1:0]          q1;
   logic [7:0]              dep1;
   mode_t                   mode1;
   logic signed [CAR_W-1:0] car2;
   logic signed [E_W-1:0]   env2;
   logic signed [P_W-1:0]   prod3;
   logic [3:0]              vld;

   logic [LUT_AW-1:0]       addr;
   logic signed [CAR_W-1:0] lv;
   logic signed [IN_W-1:0]  m;
   logic signed [MD_W-1:0]  md;
   logic signed [E_W-1:0]   env_n;
   logic signed [P_W-1:0]   shp;
   logic [DAC_W-1:0]        s;

   assign addr = q1[LUT_AW] ? ~q1[LUT_AW-1:0] : q1[LUT_AW-1:0];
   assign lv   = lut[addr];
   assign m    = {~mod1[IN_W-1], mod1[IN_W-2:0]};
   assign md   = MD_W'(m) * MD_W'($signed({1'b0, dep1}));

   always_comb begin
      env_n = '0;
      unique case (mode1)
         M_AM:   env_n = HALF + E_W'(md >>> 8);
         M_DSB:  env_n = E_W'(m);
         M_CAR:  env_n = HALF;
         M_MUTE: env_n = '0;
      endcase
   end

   assign shp = prod3 >>> SH;
   assign s   = (shp > SMAX) ? SMAX[DAC_W-1:0] :
                (shp < SMIN) ? SMIN[DAC_W-1:0] : shp[DAC_W-1:0];

   assign out_valid = vld[3];

   always_ff @(posedge CLK) begin
      if (RST) begin
         mod1    <= '0;
         q1      <= '0;
         dep1    <= '0;
         mode1   <= M_AM;
         car2    <= '0;
         env2    <= '0;
         prod3   <= '0;
         dac_out <= MID;
         vld     <= '0;
      end else begin
         mod1    <= mod_in;
         q1      <= phase[PHASE_W-1 -: Q_W];
         dep1    <= dep_a;
         mode1   <= mode_a;
         car2    <= q1[Q_W-1] ? -lv : lv;
         env2    <= env_n;
         prod3   <= P_W'(env2) * P_W'(car2);
         dac_out <= {~s[DAC_W-1], s[DAC_W-2:0]} ^ INV_MASK;
         vld     <= {vld[2:0], 1'b1};
      end
   end

endmodule

// File: tb/tb_am_nco_modulator.sv
// Directed bench for am_nco_modulator at default parameters:
// reset, carrier/AM/DSB output words, config apply timing, reset with pending config.
module tb_am_nco_modulator;

   logic        CLK = 1'b0;
   logic        RST;
   logic [11:0] mod_in;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_ftw;
   logic [7:0]  cfg_depth;
   logic [1:0]  cfg_mode;
   logic [13:0] dac_out;
   logic        out_valid;
   logic        phase_wrap;

   int checks   = 0;
   int failures = 0;
   int jj       = 0;

   always #5 CLK = ~CLK;

   am_nco_modulator dut (
      .CLK        (CLK),
      .RST        (RST),
      .mod_in     (mod_in),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ftw    (cfg_ftw),
      .cfg_depth  (cfg_depth),
      .cfg_mode   (cfg_mode),
      .dac_out    (dac_out),
      .out_valid  (out_valid),
      .phase_wrap (phase_wrap)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // request a config, then wait (bounded) for it to become active
   task automatic apply_cfg(input logic [31:0] ftw, input logic [7:0] dep,
                            input logic [1:0] md, input logic exp_wrap,
                            input int exp_n, input logic junk);
      int n;
      cfg_valid = 1'b1;
      cfg_ftw   = ftw;
      cfg_depth = dep;
      cfg_mode  = md;
      tick();
      chk("xfer_rdy", 32'(cfg_ready), 32'd0);
      if (junk) begin
         cfg_ftw  = 32'h8000_0000;
         cfg_mode = 2'd3;
      end else begin
         cfg_valid = 1'b0;
      end
      n = 0;
      while (cfg_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      cfg_valid = 1'b0;
      chk("apply_n", 32'(n), 32'(exp_n));
      chk("apply_wrap", 32'(phase_wrap), 32'(exp_wrap));
      jj = 0;
   endtask

   // ftw = 2^30: carrier index cycles every 4 samples
   task automatic run(input int last, input int from, input int s0,
                      input int s1, input int s2, input int s3,
                      input logic ramp);
      int seq [4];
      seq = '{s0, s1, s2, s3};
      while (jj < last) begin
         if (ramp) mod_in = 12'(jj * 317);
         tick();
         jj++;
         if (jj >= from)
            chk("dac", 32'(dac_out), 32'(seq[(jj-4)%4]));
         chk("wrap", 32'(phase_wrap), 32'(jj % 4 == 0));
      end
   endtask

   initial begin
      RST       = 1'b1;
      mod_in    = '0;
      cfg_valid = 1'b0;
      cfg_ftw   = '0;
      cfg_depth = '0;
      cfg_mode  = '0;

      for (int i = 0; i < 3; i++) begin
         mod_in    = 12'($urandom);
         cfg_valid = 1'($urandom);
         cfg_ftw   = $urandom;
         cfg_depth = 8'($urandom);
         cfg_mode  = 2'($urandom);
         tick();
         chk("rst_dac", 32'(dac_out), 32'd8192);
         chk("rst_ov", 32'(out_valid), 32'd0);
         chk("rst_rdy", 32'(cfg_ready), 32'd1);
      end

      RST       = 1'b0;
      cfg_valid = 1'b0;
      mod_in    = 12'd1000;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("ov_rel", 32'(out_valid), 32'(i == 4));
      end
      chk("dflt_dac", 32'(dac_out), 32'd8204);

      apply_cfg(32'h4000_0000, 8'd0, 2'd2, 1'b0, 1, 1'b0);
      run(8, 4, 8204, 12286, 8180, 4098, 1'b0);

      apply_cfg(32'h4000_0000, 8'd0, 2'd0, 1'b1, 3, 1'b0);
      run(8, 4, 8204, 12286, 8180, 4098, 1'b1);

      mod_in = 12'd0;
      apply_cfg(32'h4000_0000, 8'd255, 2'd0, 1'b1, 3, 1'b0);
      run(8, 4, 8192, 8207, 8191, 8176, 1'b0);

      mod_in = 12'd2048;
      apply_cfg(32'h4000_0000, 8'd0, 2'd1, 1'b1, 3, 1'b0);
      run(8, 4, 8192, 8192, 8192, 8192, 1'b0);
      mod_in = 12'd4095;
      run(16, 12, 8203, 12284, 8180, 4099, 1'b0);

      apply_cfg(32'h1000_0000, 8'd0, 2'd2, 1'b1, 3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wrap28", 32'(phase_wrap), 32'd0);
      end
      apply_cfg(32'h2000_0000, 8'd0, 2'd2, 1'b1, 10, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("wrap29", 32'(phase_wrap), 32'(i == 8));
      end
      apply_cfg(32'h0000_0000, 8'd0, 2'd2, 1'b1, 7, 1'b0);
      apply_cfg(32'h4000_0000, 8'd0, 2'd2, 1'b0, 1, 1'b0);
      run(8, 4, 8204, 12286, 8180, 4098, 1'b0);

      cfg_valid = 1'b1;
      cfg_ftw   = 32'h1000_0000;
      cfg_depth = 8'd0;
      cfg_mode  = 2'd3;
      tick();
      cfg_valid = 1'b0;
      chk("pend_rdy", 32'(cfg_ready), 32'd0);
      RST    = 1'b1;
      mod_in = 12'd4095;
      tick();
      chk("mid_rst_dac", 32'(dac_out), 32'd8192);
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      chk("mid_rst_rdy", 32'(cfg_ready), 32'd1);
      chk("mid_rst_wrap", 32'(phase_wrap), 32'd0);
      tick();
      RST = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         mod_in = 12'(i * 500);
         tick();
         chk("post_ov", 32'(out_valid), 32'(i >= 4));
         if (i >= 4) chk("post_dac", 32'(dac_out), 32'd8204);
         chk("post_wrap", 32'(phase_wrap), 32'd0);
         chk("post_rdy", 32'(cfg_ready), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
